// File: rtl/prio_enc_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_rr_if
// Brief    : Request/result handshake bundle for prio_enc_rr.
//            master = producer/consumer side, slave = encoder side.
// Revision : 1.0  initial release
// ============================================================================
interface prio_enc_rr_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_none;
  logic             out_multi;

  modport master (
    output req_valid, req, out_ready,
    input  req_ready, out_valid, out_idx, out_none, out_multi
  );

  modport slave (
    input  req_valid, req, out_ready,
    output req_ready, out_valid, out_idx, out_none, out_multi
  );
endinterface
`default_nettype wire

// File: rtl/prio_enc_rr.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_rr
// Brief    : Registered priority encoder with valid/ready on both sides.
//            Reports winning index, all-zero and multiple-request flags.
//            Optional round-robin priority rotation, enabled by defining
//            the macro PRIO_ENC_ROUND_ROBIN_EN.
// Revision : 1.0  initial release
// ============================================================================
module prio_enc_rr #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  prio_enc_rr_if.slave     bus
);

  localparam logic [IDX_W-1:0] c_PTR_TOP = IDX_W'(WIDTH - 1);

  logic             w_fire;
  logic             w_none;
  logic             w_multi;
  logic [IDX_W-1:0] w_idx;

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_none;
  logic             r_multi;

  // Accept whenever the result slot is empty or being drained this cycle.
  assign bus.req_ready = !r_valid || bus.out_ready;
  assign w_fire        = bus.req_valid && bus.req_ready;

  // Zero / multiple-request flags from the raw request vector.
  always_comb begin
    w_none  = 1'b1;
    w_multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.req[i]) begin
        if (!w_none) w_multi = 1'b1;
        w_none = 1'b0;
      end
    end
  end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  int               w_dist;
  int               w_best;

  // Winner is the set bit closest to r_ptr going downward with wrap.
  always_comb begin
    w_idx  = '0;
    w_best = WIDTH;
    w_dist = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dist = int'(r_ptr) - i;
      if (w_dist < 0) w_dist = w_dist + WIDTH;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_idx  = IDX_W'(i);
      end
    end
  end

  // Last winner drops to lowest priority; all-zero accepts leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= c_PTR_TOP;
    end else if (w_fire && !w_none) begin
      r_ptr <= (w_idx == '0) ? c_PTR_TOP : (w_idx - 1'b1);
    end
  end
`else
  // Fixed priority: highest set index wins (later iterations override).
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.req[i]) w_idx = IDX_W'(i);
    end
  end
`endif

  // Result register: load on accept, clear valid on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_none  <= 1'b0;
      r_multi <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_idx   <= w_idx;
      r_none  <= w_none;
      r_multi <= w_multi;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_idx   = r_idx;
  assign bus.out_none  = r_none;
  assign bus.out_multi = r_multi;

endmodule
`default_nettype wire

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered priority encoder with valid/ready handshakes on both sides. It is the next generation of the lab-series combinational encoder. Each accepted request vector is reduced to the index of the winning set bit, plus "none" and "multiple" flags, and held in an output register until the consumer takes it. An optional round-robin mode rotates priority after each grant, so the same block can serve as a simple N-way arbiter in later lab designs.

## Interface
Parameters:
- WIDTH, 16, number of request lines; legal range 2..256.
- IDX_W, $clog2(WIDTH), width of the index output; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  producer has a request vector on req.
- req_ready  output  1  block can accept a vector this cycle.
- req  input  WIDTH  request vector; bit i set = line i requesting.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- out_idx  output  IDX_W  index of the winning line.
- out_none  output  1  accepted vector was all-zero.
- out_multi  output  1  accepted vector had two or more bits set.

## Operation
- Accept condition: req_valid && req_ready.
- req_ready = !out_valid || out_ready. This is combinational: the block accepts a new vector in the same cycle the old result drains.
- On accept, the result register loads:
  - the winner's index into out_idx;
  - out_none = (req == 0);
  - out_multi = (popcount(req) >= 2).
- On accept, out_valid is set to 1.
- If out_valid && out_ready and there is no accept in the same cycle, out_valid clears to 0.
- If neither event occurs, all output fields hold. Results are never overwritten before they are consumed.
- All-zero vector: out_idx = 0, out_none = 1, out_multi = 0, out_valid = 1. An all-zero vector is still a handshake and produces a result.
- Fixed-priority winner: the highest set index, so bit WIDTH-1 has top priority.
- req is sampled only on accept. Changes to req while req_valid=0 or req_ready=0 have no effect.
- There is no internal FSM beyond the out_valid flag, plus the pointer described under Configuration.

## Timing
- Latency: a vector accepted on edge n appears on out_* after edge n and stays until the edge where out_ready=1.
- Throughput: one result per cycle while out_ready is held high.
- Simultaneous drain and accept: the new result replaces the old one on the same edge, and out_valid stays 1.
- Reset values (asynchronous, immediate on rst_n low):
  - out_valid = 0, out_idx = 0, out_none = 0, out_multi = 0;
  - round-robin pointer = WIDTH-1.
- Reset mid-operation: any pending result is discarded with no further handshake. req_ready goes to 1 once reset is asserted.
- Reset deassertion is assumed synchronised externally. The first accept is allowed on the first edge after release.
- out_* are driven only from registers. req_ready is the only combinational output.

## Configuration
- Macro: PRIO_ENC_ROUND_ROBIN_EN.
- Defined: the block holds an IDX_W-bit pointer ptr, reset to WIDTH-1.
  - The search starts at ptr and moves downward, wrapping from 0 to WIDTH-1. The first set bit found wins.
  - After an accept with out_none=0 and winner k, ptr becomes k-1 mod WIDTH (k=0 wraps to WIDTH-1). The last winner therefore has lowest priority next time.
  - An all-zero accept leaves ptr unchanged.
- Not defined: no pointer register exists and the winner is always the highest set index. The port list is identical in both builds.
- With the macro defined, the first grant after reset matches fixed priority.

## Test plan (WIDTH=16)
- Reset and idle: rst_n=0 -> out_valid=0, out_idx=0, out_none=0, out_multi=0, req_ready=1.
- Fixed priority: accept req=16'h0A40 -> next cycle out_idx=11, out_multi=1, out_none=0, out_valid=1. Accept req=16'h0001 -> out_idx=0, out_multi=0.
- Zero vector: accept req=16'h0000 -> out_none=1, out_idx=0, out_valid=1.
- Backpressure: out_ready=0 after a result of 5, then present req=16'h8000 for 3 cycles -> req_ready=0, out_idx stays 5. Raise out_ready -> same-cycle accept, next out_idx=15, out_valid continuous.
- Round robin (macro defined): accept req=16'h8101 four times -> out_idx 15, 8, 0, 15. Without the macro -> 15, 15, 15, 15.
- Reset mid-operation: with out_valid=1 and out_ready=0, pulse rst_n low between edges -> out_valid drops immediately. After release, ptr has reset to 15 and req=16'h8101 yields 15.
